// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter granting one core at a time access to a shared data memory
module dmem_arbiter #(
    parameter int N_CORES = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_CORES-1:0]   core_req_i,
    input  logic [N_CORES-1:0]   core_we_i,
    input  logic [32*N_CORES-1:0] core_addr_i,
    input  logic [32*N_CORES-1:0] core_wdata_i,
    output logic [N_CORES-1:0]   core_ack_o,
    output logic                 core_err_o,
    output logic [31:0]          core_rdata_o,
    output logic [N_CORES-1:0]   core_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 mem_ack_i
);
    localparam int IW = $clog2(N_CORES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d, grant_q, grant_d, sel;
    logic            we_q, we_d, err_q, err_d, found, timeout;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]      cnt_q, cnt_d;
    int              idx;

    assign timeout = cnt_q == 8'(TIMEOUT - 1);

    // pick the first requesting core at or after the round-robin pointer, wrapping around
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = (int'(rr_q) + k) % N_CORES;
            if (!found && core_req_i[idx]) begin
                found = 1'b1;
                sel   = IW'(idx);
            end
        end
    end

    // FSM state register; reset abandons any in-flight transaction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: arbitrate only in IDLE, leave BUSY on ack or timeout, DONE lasts one cycle
    always_comb begin
        state_d = (state_q == IDLE) ? (found ? BUSY : IDLE) :
                  (state_q == BUSY) ? ((mem_ack_i || timeout) ? DONE : BUSY) : IDLE;
    end

    // FSM outputs: memory side driven from latched request, ack pulses only in DONE
    always_comb begin
        mem_req_o            = state_q == BUSY;
        mem_we_o             = (state_q == BUSY) && we_q;
        mem_addr_o           = addr_q;
        mem_wdata_o          = wdata_q;
        core_ack_o           = '0;
        core_ack_o[grant_q]  = state_q == DONE;
        core_err_o           = (state_q == DONE) && err_q;
        core_rdata_o         = rdata_q;
        core_stall_o         = core_req_i & ~core_ack_o;
    end

    // datapath next state: latch on grant, capture load data or timeout, advance pointer on completion
    always_comb begin
        rr_d    = rr_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && found) begin
            grant_d = sel;
            we_d    = core_we_i[sel];
            addr_d  = core_addr_i[32*sel +: 32];
            wdata_d = core_wdata_i[32*sel +: 32];
            cnt_d   = '0;
        end
        if (state_q == BUSY) begin
            if (mem_ack_i) begin
                rdata_d = we_q ? rdata_q : mem_rdata_i;
                err_d   = 1'b0;
            end else if (timeout) begin
                err_d   = 1'b1;
            end else begin
                cnt_d   = cnt_q + 8'd1;
            end
        end
        if (state_q == DONE) rr_d = (grant_q == IW'(N_CORES - 1)) ? '0 : grant_q + 1'b1;
    end

    // datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= '0;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, latency, timeout and reset behaviour
module tb_dmem_arbiter;
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [3:0]   core_req_i = '0, core_we_i = '0;
    logic [127:0] core_addr_i = '0, core_wdata_i = '0;
    logic [3:0]   core_ack_o, core_stall_o;
    logic         core_err_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]  core_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

    logic         mem_en = 1'b1, spur = 1'b0;
    int           lat = 0, wcnt = 0;
    logic [31:0]  mem [0:255];
    int           n_tests = 0, n_fail = 0;
    logic [3:0]   rr_exp [6];
    logic [3:0]   who;
    int           n, cnt;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.N_CORES(4), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_i(core_req_i), .core_we_i(core_we_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_ack_o(core_ack_o), .core_err_o(core_err_o),
        .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    // memory model: ack after lat wait cycles, 0x100 is a fixed read-only word
    assign mem_ack_i   = (mem_en && mem_req_o && wcnt >= lat) || spur;
    assign mem_rdata_i = (mem_addr_o == 32'h100) ? 32'hDEADBEEF : mem[mem_addr_o[9:2]];

    always @(posedge clk_i) begin
        wcnt <= (mem_req_o && !mem_ack_i) ? wcnt + 1 : 0;
        if (mem_req_o && mem_we_o && mem_ack_i) mem[mem_addr_o[9:2]] <= mem_wdata_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(output logic [3:0] w, output int c);
        w = '0;
        c = 0;
        while (w == 0 && c < 40) begin
            tick();
            c++;
            w = core_ack_o;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        core_req_i = 4'b0001;
        tick();
        tick();
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_ack", core_ack_o, 0);
        chk("rst_err", core_err_o, 0);
        chk("rst_rdata", core_rdata_o, 0);
        core_req_i = '0;
        rst_ni = 1'b1;

        // single load from core 2 with one memory wait cycle
        core_addr_i[64 +: 32] = 32'h100;
        core_req_i = 4'b0100;
        lat = 1;
        tick();
        chk("ld_mem_req", mem_req_o, 1);
        chk("ld_mem_addr", mem_addr_o, 32'h100);
        chk("ld_mem_we", mem_we_o, 0);
        tick();
        chk("ld_ack_early", core_ack_o, 0);
        tick();
        chk("ld_ack", core_ack_o, 4'b0100);
        chk("ld_rdata", core_rdata_o, 32'hDEADBEEF);
        chk("ld_err", core_err_o, 0);
        core_req_i = '0;
        tick();
        chk("ld_ack_once", core_ack_o, 0);
        chk("ld_rdata_hold", core_rdata_o, 32'hDEADBEEF);

        // round robin among cores 0,1,3 from a fresh reset
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        lat = 0;
        core_addr_i = {4{32'h100}};
        core_req_i = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            wait_ack(who, n);
            chk($sformatf("rr_grant%0d", i), who, rr_exp[i]);
            chk($sformatf("rr_cycles%0d", i), n, i == 0 ? 2 : 3);
        end
        core_req_i = '0;
        tick();

        // store then load back from core 1; later edits to core inputs must not leak
        core_we_i[1] = 1'b1;
        core_addr_i[32 +: 32] = 32'h40;
        core_wdata_i[32 +: 32] = 32'h12345678;
        core_req_i = 4'b0010;
        lat = 2;
        tick();
        chk("st_mem_we", mem_we_o, 1);
        chk("st_mem_addr", mem_addr_o, 32'h40);
        chk("st_mem_wdata", mem_wdata_o, 32'h12345678);
        core_wdata_i[32 +: 32] = 32'hBAD0BAD0;
        core_addr_i[32 +: 32] = 32'h44;
        core_we_i[1] = 1'b0;
        tick();
        chk("st_wdata_hold", mem_wdata_o, 32'h12345678);
        chk("st_addr_hold", mem_addr_o, 32'h40);
        chk("st_we_hold", mem_we_o, 1);
        wait_ack(who, n);
        chk("st_ack", who, 4'b0010);
        chk("st_rdata_kept", core_rdata_o, 32'hDEADBEEF);
        core_req_i = '0;
        tick();
        core_addr_i[32 +: 32] = 32'h40;
        core_req_i = 4'b0010;
        wait_ack(who, n);
        chk("rb_ack", who, 4'b0010);
        chk("rb_rdata", core_rdata_o, 32'h12345678);
        core_req_i = '0;
        tick();

        // timeout: memory never answers core 3
        mem_en = 1'b0;
        core_addr_i[96 +: 32] = 32'h80;
        core_req_i = 4'b1000;
        cnt = 0;
        for (int i = 0; i < 20 && core_ack_o == 0; i++) begin
            tick();
            if (mem_req_o) cnt++;
        end
        chk("to_mreq_cycles", cnt, 8);
        chk("to_ack", core_ack_o, 4'b1000);
        chk("to_err", core_err_o, 1);
        chk("to_rdata", core_rdata_o, 32'h12345678);
        core_req_i = '0;
        mem_en = 1'b1;
        tick();

        // move the pointer past core 1, then reset in the middle of a core 2 transaction
        lat = 0;
        core_addr_i[32 +: 32] = 32'h100;
        core_req_i = 4'b0010;
        wait_ack(who, n);
        chk("pre_rst_ack", who, 4'b0010);
        core_req_i = '0;
        tick();
        mem_en = 1'b0;
        core_req_i = 4'b0100;
        tick();
        chk("mid_busy", mem_req_o, 1);
        core_req_i = 4'b0101;
        #3 rst_ni = 1'b0;
        #1;
        chk("mid_rst_async", mem_req_o, 0);
        chk("mid_rst_ack", core_ack_o, 0);
        tick();
        chk("mid_rst_noack", core_ack_o, 0);
        rst_ni = 1'b1;
        mem_en = 1'b1;
        wait_ack(who, n);
        chk("post_rst_grant", who, 4'b0001);
        core_req_i = '0;
        tick();

        // stalls during memory wait, spurious acks outside BUSY, early request drop
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        spur = 1'b1;
        tick();
        tick();
        chk("spur_idle_ack", core_ack_o, 0);
        chk("spur_idle_mreq", mem_req_o, 0);
        spur = 1'b0;
        lat = 3;
        core_req_i = 4'b0011;
        tick();
        chk("stall_wait1", core_stall_o[1:0], 2'b11);
        tick();
        chk("stall_wait2", core_stall_o[1:0], 2'b11);
        chk("stall_noack", core_ack_o, 0);
        wait_ack(who, n);
        chk("stall_grant0", who, 4'b0001);
        chk("stall_grant0_lat", n, 3);
        chk("stall_at_ack", core_stall_o, 4'b0010);
        core_req_i = 4'b0010;
        spur = 1'b1;
        tick();
        chk("spur_done_ack", core_ack_o, 0);
        spur = 1'b0;
        tick();
        chk("g1_busy", mem_req_o, 1);
        core_req_i = '0;
        wait_ack(who, n);
        chk("g1_ack_after_drop", who, 4'b0010);
        tick();
        chk("g1_ack_once", core_ack_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter N_CORES, default 4: number of requesting cores (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255: max cycles in BUSY without mem_ack (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port core_req  input  N_CORES  per-core access request; held until core_ack.
REQ-006 SHALL have port core_we  input  N_CORES  per-core write enable (1=store, 0=load).
REQ-007 SHALL have port core_addr  input  32*N_CORES  per-core byte address; core i at [32*i+31:32*i].
REQ-008 SHALL have port core_wdata  input  32*N_CORES  per-core store data, same packing.
REQ-009 SHALL have port core_ack  output  N_CORES  one-cycle completion pulse to granted core.
REQ-010 SHALL have port core_err  output  1  valid with core_ack; 1 = transaction timed out.
REQ-011 SHALL have port core_rdata  output  32  load data, shared bus, valid with core_ack.
REQ-012 SHALL have port core_stall  output  N_CORES  pipeline stall per core.
REQ-013 SHALL have port mem_req  output  1  request to shared data memory.
REQ-014 SHALL have port mem_we  output  1  memory write enable.
REQ-015 SHALL have port mem_addr  output  32  memory address.
REQ-016 SHALL have port mem_wdata  output  32  memory store data.
REQ-017 SHALL have port mem_rdata  input  32  memory load data, valid with mem_ack.
REQ-018 SHALL have port mem_ack  input  1  memory completion, variable latency (zero or more cycles after mem_req).

Function
REQ-019 SHALL implement FSM states IDLE, BUSY, DONE; one transaction in flight maximum.
REQ-020 IDLE: if any core_req, SHALL grant lowest index i at or after rr_ptr (cyclic), latch i, we, addr, wdata into registers, go BUSY; else stay IDLE.
REQ-021 BUSY: mem_req=1; mem_we/mem_addr/mem_wdata SHALL come from latched registers, stable until exit from BUSY.
REQ-022 BUSY with mem_ack=1: SHALL load mem_rdata into rdata register only if latched we=0, clear err, go DONE.
REQ-023 BUSY: wait counter increments each cycle without mem_ack; when counter equals TIMEOUT-1 and no mem_ack, SHALL set err=1, go DONE without loading rdata.
REQ-024 DONE: core_ack[grant]=1 for exactly one cycle, core_err=err; rr_ptr SHALL become (grant+1) mod N_CORES; next state IDLE.
REQ-025 Latency: request sampled in IDLE at cycle T with mem_ack in first BUSY cycle -> core_ack at cycle T+2; each extra memory wait cycle adds one.
REQ-026 core_rdata SHALL hold the rdata register continuously; unchanged by stores or timeouts.
REQ-027 core_stall[i] SHALL equal core_req[i] AND NOT core_ack[i] (combinational).
REQ-028 Requests arriving in BUSY or DONE SHALL wait; arbitration occurs only in IDLE, so back-to-back grants are separated by one IDLE cycle.
REQ-029 Deassertion of core_req by the granted core after grant SHALL NOT abort; transaction completes and ack still pulses.
REQ-030 mem_ack in IDLE or DONE SHALL be ignored.
REQ-031 mem_req, mem_we SHALL be 0 outside BUSY; mem_addr/mem_wdata hold latched values.
REQ-032 Changes on core_addr/core_wdata/core_we after grant SHALL NOT affect the in-flight transaction.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, rr_ptr=0, counter=0, err=0, grant=0, all latched and rdata registers=0; thus core_ack=0, core_err=0, core_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset during BUSY SHALL drop mem_req same instant; in-flight transaction is discarded, no ack issued.

Verification
REQ-035 Single load: core 2 req, we=0, addr=0x100; mem_ack 1 cycle later with rdata=0xDEADBEEF -> mem_addr=0x100, core_ack=4'b0100 once, core_rdata=0xDEADBEEF, core_err=0.
REQ-036 Round robin: cores 0,1,3 request continuously from reset -> grant order 0,1,3,0,1,3; no core granted twice before others served.
REQ-037 Store then read-back: core 1 stores 0x12345678 to 0x40, then loads 0x40 (memory model) -> mem_we=1 during first BUSY, core_rdata=0x12345678 after second ack, unchanged between.
REQ-038 Timeout: TIMEOUT=8, mem_ack never asserted -> mem_req high exactly 8 cycles, then core_ack pulse with core_err=1, core_rdata unchanged.
REQ-039 Reset mid-BUSY: rst=0 while mem_req=1 -> mem_req=0 asynchronously, no core_ack; after release, pending core 0 request granted from rr_ptr=0.
REQ-040 Stall/ignore: core 0 held by 3 memory wait cycles while core 1 requests; spurious mem_ack in IDLE -> core_stall=2'b11 during wait, no spurious ack, core 1 granted after core 0 ack.
